// File: rtl/ps2_mouse_rx.sv
// PS/2 mouse receiver: synchronises and filters the PS/2 clock, deframes
// 11-bit frames, assembles 3-byte movement packets and integrates them into
// a saturating cursor position with button state.
// Optional feature: define PS2_PARITY_CHECK_EN to reject bytes whose odd
// parity fails; otherwise the parity bit is clocked through and ignored.
// Handshake: pkt_valid and frame_err are single-cycle strobes with no ready;
// xpos/ypos/left/right are stable whenever pkt_valid is low.
module ps2_mouse_rx #(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 100000,
  parameter int X_MAX       = 799,
  parameter int Y_MAX       = 599
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [11:0] xpos,
  output logic [11:0] ypos,
  output logic        left,
  output logic        right,
  output logic        pkt_valid,
  output logic        frame_err
);

  localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN + 1) : 1;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic signed [12:0] X_MAX_S = 13'(X_MAX);
  localparam logic signed [12:0] Y_MAX_S = 13'(Y_MAX);
  localparam logic [11:0] X_RST = 12'((X_MAX + 1) / 2);
  localparam logic [11:0] Y_RST = 12'((Y_MAX + 1) / 2);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic          clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
  logic          filt_clk_q, filt_clk_d;
  logic [FW-1:0] filt_cnt_q, filt_cnt_d;
  logic          fall_now;
  state_t        state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
`ifdef PS2_PARITY_CHECK_EN
  logic          parity_q, parity_d;
`endif
  logic          byte_done, byte_ok;
  logic [1:0]    pkt_idx_q, pkt_idx_d;
  // Byte 0 fields kept: {y_ovf, x_ovf, y_sign, x_sign, right, left}
  logic [5:0]    b0_q, b0_d;
  logic [7:0]    b1_q, b1_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          timeout;
  logic [11:0]   xpos_q, xpos_d, ypos_q, ypos_d;
  logic          left_q, left_d, right_q, right_d;
  logic          pkt_valid_q, pkt_valid_d, frame_err_q, frame_err_d;
  logic signed [12:0] dx_s, dy_s, x_sum, y_sum;
  logic [11:0]   x_sat, y_sat;

  // Two-flop synchronisers for both asynchronous PS/2 lines
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_s1_q <= 1'b1;
      clk_s2_q <= 1'b1;
      dat_s1_q <= 1'b1;
      dat_s2_q <= 1'b1;
    end else begin
      clk_s1_q <= ps2_clk;
      clk_s2_q <= clk_s1_q;
      dat_s1_q <= ps2_data;
      dat_s2_q <= dat_s1_q;
    end
  end

  // Glitch filter: flip the filtered clock after FILTER_LEN differing samples
  always_comb begin
    filt_clk_d = filt_clk_q;
    filt_cnt_d = '0;
    fall_now   = 1'b0;
    if (clk_s2_q != filt_clk_q) begin
      if (filt_cnt_q == FW'(FILTER_LEN - 1)) begin
        filt_clk_d = clk_s2_q;
        fall_now   = filt_clk_q;
      end else begin
        filt_cnt_d = filt_cnt_q + FW'(1);
      end
    end
  end

  // Idle watchdog: runs while a frame or packet is partially received
  always_comb begin
    tmo_d   = '0;
    timeout = 1'b0;
    if (((state_q != IDLE) || (pkt_idx_q != 2'd0)) && !fall_now) begin
      if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
        timeout = 1'b1;
      end else begin
        tmo_d = tmo_q + TW'(1);
      end
    end
  end

  // Frame FSM next state: start, 8 data bits LSB first, parity, stop
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
`ifdef PS2_PARITY_CHECK_EN
    parity_d  = parity_q;
`endif
    byte_done = 1'b0;
    if (timeout) begin
      state_d = IDLE;
    end else if (fall_now) begin
      case (state_q)
        IDLE: begin
          if (!dat_s2_q) begin
            state_d   = DATA;
            bit_cnt_d = 3'd0;
          end
        end
        DATA: begin
          shift_d   = {dat_s2_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = PARITY;
        end
        PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
          parity_d = dat_s2_q;
`endif
          state_d  = STOP;
        end
        STOP: begin
          byte_done = 1'b1;
          state_d   = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Byte acceptance: stop bit high, plus odd parity when checking is enabled
  always_comb begin
`ifdef PS2_PARITY_CHECK_EN
    byte_ok = dat_s2_q && (^{shift_q, parity_q});
`else
    byte_ok = dat_s2_q;
`endif
  end

  // Position arithmetic at 13-bit signed width with saturation
  always_comb begin
    dx_s  = {{4{b0_q[2]}}, b0_q[2], b1_q};
    dy_s  = {{4{b0_q[3]}}, b0_q[3], shift_q};
    x_sum = $signed({1'b0, xpos_q}) + dx_s;
    y_sum = $signed({1'b0, ypos_q}) - dy_s;
    if (x_sum < 13'sd0)        x_sat = 12'd0;
    else if (x_sum > X_MAX_S)  x_sat = 12'(X_MAX);
    else                       x_sat = x_sum[11:0];
    if (y_sum < 13'sd0)        y_sat = 12'd0;
    else if (y_sum > Y_MAX_S)  y_sat = 12'(Y_MAX);
    else                       y_sat = y_sum[11:0];
  end

  // Packet assembler: resyncs on byte 0 bit 3, publishes on byte 2
  always_comb begin
    pkt_idx_d   = pkt_idx_q;
    b0_d        = b0_q;
    b1_d        = b1_q;
    xpos_d      = xpos_q;
    ypos_d      = ypos_q;
    left_d      = left_q;
    right_d     = right_q;
    pkt_valid_d = 1'b0;
    frame_err_d = 1'b0;
    if (timeout) begin
      pkt_idx_d   = 2'd0;
      frame_err_d = 1'b1;
    end else if (byte_done) begin
      if (!byte_ok) begin
        pkt_idx_d   = 2'd0;
        frame_err_d = 1'b1;
      end else begin
        case (pkt_idx_q)
          2'd0: begin
            if (shift_q[3]) begin
              b0_d      = {shift_q[7:4], shift_q[1:0]};
              pkt_idx_d = 2'd1;
            end
          end
          2'd1: begin
            b1_d      = shift_q;
            pkt_idx_d = 2'd2;
          end
          default: begin
            pkt_idx_d   = 2'd0;
            pkt_valid_d = 1'b1;
            left_d      = b0_q[0];
            right_d     = b0_q[1];
            if (!b0_q[4]) xpos_d = x_sat;
            if (!b0_q[5]) ypos_d = y_sat;
          end
        endcase
      end
    end
  end

  // State registers
  always_ff @(posedge clk) begin
    if (rst) begin
      filt_clk_q  <= 1'b1;
      filt_cnt_q  <= '0;
      state_q     <= IDLE;
      bit_cnt_q   <= 3'd0;
      shift_q     <= 8'd0;
`ifdef PS2_PARITY_CHECK_EN
      parity_q    <= 1'b0;
`endif
      pkt_idx_q   <= 2'd0;
      b0_q        <= 6'd0;
      b1_q        <= 8'd0;
      tmo_q       <= '0;
      xpos_q      <= X_RST;
      ypos_q      <= Y_RST;
      left_q      <= 1'b0;
      right_q     <= 1'b0;
      pkt_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      filt_clk_q  <= filt_clk_d;
      filt_cnt_q  <= filt_cnt_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
`ifdef PS2_PARITY_CHECK_EN
      parity_q    <= parity_d;
`endif
      pkt_idx_q   <= pkt_idx_d;
      b0_q        <= b0_d;
      b1_q        <= b1_d;
      tmo_q       <= tmo_d;
      xpos_q      <= xpos_d;
      ypos_q      <= ypos_d;
      left_q      <= left_d;
      right_q     <= right_d;
      pkt_valid_q <= pkt_valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign xpos      = xpos_q;
  assign ypos      = ypos_q;
  assign left      = left_q;
  assign right     = right_q;
  assign pkt_valid = pkt_valid_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_ps2_mouse_rx.sv
// Bench for ps2_mouse_rx: drives PS/2 frames bit by bit, keeps a plain
// integer cursor model and counts output strobes with a negedge monitor.
module tb_ps2_mouse_rx;

  localparam int FL   = 8;
  localparam int TMO  = 2000;
  localparam int XM   = 799;
  localparam int YM   = 599;
  localparam int HALF = 24;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ps2_clk = 1'b1;
  logic        ps2_data = 1'b1;
  logic [11:0] xpos, ypos;
  logic        left, right, pkt_valid, frame_err;

  // Clock and reset block
  always #5 clk = ~clk;

  ps2_mouse_rx #(.FILTER_LEN(FL), .TIMEOUT_CYC(TMO), .X_MAX(XM), .Y_MAX(YM)) dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .xpos(xpos), .ypos(ypos), .left(left), .right(right),
    .pkt_valid(pkt_valid), .frame_err(frame_err)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int last_fall_cyc, stop_fall_cyc, last_pv_cyc;
  int pv_rise, pv_high, fe_rise, fe_high, both_cnt;
  logic pv_prev = 1'b0, fe_prev = 1'b0;

  // Reference model state
  int mx, my;
  logic ml, mr;

  always @(posedge clk) cyc++;

  // Strobe monitor, sampled away from the active edge
  always @(negedge clk) begin
    if (pkt_valid) begin
      pv_high++;
      if (!pv_prev) pv_rise++;
      last_pv_cyc = cyc;
    end
    if (frame_err) begin
      fe_high++;
      if (!fe_prev) fe_rise++;
    end
    if (pkt_valid && frame_err) both_cnt++;
    pv_prev = pkt_valid;
    fe_prev = frame_err;
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    pv_rise = 0; pv_high = 0; fe_rise = 0; fe_high = 0;
  endtask

  task automatic apply_reset();
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    rst      = 1'b1;
    wait_cycles(3);
    rst = 1'b0;
    mx = (XM + 1) / 2;
    my = (YM + 1) / 2;
    ml = 1'b0;
    mr = 1'b0;
    clear_mon();
  endtask

  // Driver: one PS/2 bit cell, data set while clock high, host samples on fall
  task automatic send_bit(input logic b, input bit glitch);
    ps2_data = b;
    if (glitch) begin
      wait_cycles(12);
      ps2_clk = 1'b0;
      wait_cycles(FL - 1);
      ps2_clk = 1'b1;
      wait_cycles(HALF - 12 - (FL - 1));
    end else begin
      wait_cycles(HALF);
    end
    ps2_clk = 1'b0;
    last_fall_cyc = cyc;
    wait_cycles(HALF);
    ps2_clk = 1'b1;
  endtask

  // Driver: full 11-bit frame; glitch_at selects a frame bit to disturb (-1 none)
  task automatic send_byte(input logic [7:0] b, input bit bad_par, input int glitch_at);
    logic par;
    par = ~(^b) ^ bad_par;
    send_bit(1'b0, glitch_at == 0);
    for (int i = 0; i < 8; i++) send_bit(b[i], glitch_at == i + 1);
    send_bit(par, glitch_at == 9);
    send_bit(1'b1, glitch_at == 10);
    stop_fall_cyc = last_fall_cyc;
    ps2_data = 1'b1;
    wait_cycles(10);
  endtask

  task automatic send_packet(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    send_byte(b0, 1'b0, -1);
    send_byte(b1, 1'b0, -1);
    send_byte(b2, 1'b0, -1);
    wait_cycles(20);
  endtask

  // Reference model: cursor update from one accepted packet
  task automatic model_packet(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    int dx, dy;
    dx = b0[4] ? int'(b1) - 256 : int'(b1);
    dy = b0[5] ? int'(b2) - 256 : int'(b2);
    ml = b0[0];
    mr = b0[1];
    if (!b0[6]) begin
      mx = mx + dx;
      if (mx < 0) mx = 0;
      if (mx > XM) mx = XM;
    end
    if (!b0[7]) begin
      my = my - dy;
      if (my < 0) my = 0;
      if (my > YM) my = YM;
    end
  endtask

  task automatic test_reset();
    apply_reset();
    n_tests++;
    if ({xpos, ypos, left, right} !== {12'd400, 12'd300, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_outputs: got x=%0d y=%0d l=%0b r=%0b, expected x=400 y=300 l=0 r=0", xpos, ypos, left, right);
    end
    n_tests++;
    if ({pkt_valid, frame_err} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_strobes: got pv=%0b fe=%0b, expected 0 0", pkt_valid, frame_err);
    end
    wait_cycles(FL + 10);
    n_tests++;
    if (pv_rise + fe_rise !== 0) begin
      n_fail++;
      $display("FAIL reset_quiet: got %0d pulses after reset, expected 0", pv_rise + fe_rise);
    end
  endtask

  task automatic test_basic();
    apply_reset();
    send_packet(8'h08, 8'h05, 8'h03);
    n_tests++;
    if (pv_rise !== 1 || pv_high !== 1) begin
      n_fail++;
      $display("FAIL basic_pulse: got rises=%0d high_cycles=%0d, expected 1 1", pv_rise, pv_high);
    end
    n_tests++;
    if ({xpos, ypos, left, right} !== {12'd405, 12'd297, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL basic_pos: got x=%0d y=%0d l=%0b r=%0b, expected x=405 y=297 l=0 r=0", xpos, ypos, left, right);
    end
    n_tests++;
    if ((last_pv_cyc - stop_fall_cyc) < FL + 1 || (last_pv_cyc - stop_fall_cyc) > FL + 3) begin
      n_fail++;
      $display("FAIL basic_latency: got %0d cycles from stop edge, expected %0d..%0d", last_pv_cyc - stop_fall_cyc, FL + 1, FL + 3);
    end
  endtask

  task automatic test_saturate();
    apply_reset();
    send_packet(8'h19, 8'h00, 8'h00);
    model_packet(8'h19, 8'h00, 8'h00);
    n_tests++;
    if ({xpos, ypos, left, right} !== {12'(mx), 12'(my), ml, mr} || left !== 1'b1) begin
      n_fail++;
      $display("FAIL sat_left: got x=%0d y=%0d l=%0b r=%0b, expected x=%0d y=%0d l=1 r=0", xpos, ypos, left, right, mx, my);
    end
    for (int i = 0; i < 4; i++) begin
      send_packet(8'h18, 8'h80, 8'h00);
      model_packet(8'h18, 8'h80, 8'h00);
      n_tests++;
      if ({xpos, ypos, left, right} !== {12'(mx), 12'(my), ml, mr}) begin
        n_fail++;
        $display("FAIL sat_step%0d: got x=%0d y=%0d l=%0b, expected x=%0d y=%0d l=%0b", i, xpos, ypos, left, mx, my, ml);
      end
    end
    n_tests++;
    if (xpos !== 12'd0 || ypos !== 12'd300 || pv_rise !== 5) begin
      n_fail++;
      $display("FAIL sat_final: got x=%0d y=%0d packets=%0d, expected x=0 y=300 packets=5", xpos, ypos, pv_rise);
    end
  endtask

  task automatic test_parity();
    apply_reset();
    send_byte(8'h08, 1'b1, -1);
    wait_cycles(20);
`ifdef PS2_PARITY_CHECK_EN
    n_tests++;
    if (fe_rise !== 1 || fe_high !== 1 || pv_rise !== 0) begin
      n_fail++;
      $display("FAIL parity_reject: got fe=%0d/%0d pv=%0d, expected fe=1/1 pv=0", fe_rise, fe_high, pv_rise);
    end
    send_packet(8'h08, 8'h01, 8'h00);
`else
    n_tests++;
    if (fe_rise !== 0 || pv_rise !== 0) begin
      n_fail++;
      $display("FAIL parity_ignored: got fe=%0d pv=%0d, expected fe=0 pv=0", fe_rise, pv_rise);
    end
    send_byte(8'h01, 1'b0, -1);
    send_byte(8'h00, 1'b0, -1);
    wait_cycles(20);
`endif
    n_tests++;
    if (pv_rise !== 1 || xpos !== 12'd401 || ypos !== 12'd300) begin
      n_fail++;
      $display("FAIL parity_next: got pv=%0d x=%0d y=%0d, expected pv=1 x=401 y=300", pv_rise, xpos, ypos);
    end
  endtask

  task automatic test_timeout();
    apply_reset();
    send_byte(8'h08, 1'b0, -1);
    send_byte(8'h10, 1'b0, -1);
    wait_cycles(TMO + 10);
    n_tests++;
    if (fe_rise !== 1 || fe_high !== 1 || pv_rise !== 0 || xpos !== 12'd400 || ypos !== 12'd300) begin
      n_fail++;
      $display("FAIL timeout_err: got fe=%0d/%0d pv=%0d x=%0d y=%0d, expected fe=1/1 pv=0 x=400 y=300", fe_rise, fe_high, pv_rise, xpos, ypos);
    end
    send_packet(8'h08, 8'h02, 8'h00);
    n_tests++;
    if (pv_rise !== 1 || fe_rise !== 1 || xpos !== 12'd402) begin
      n_fail++;
      $display("FAIL timeout_recover: got pv=%0d fe=%0d x=%0d, expected pv=1 fe=1 x=402", pv_rise, fe_rise, xpos);
    end
  endtask

  task automatic test_resync();
    apply_reset();
    send_byte(8'h00, 1'b0, -1);
    wait_cycles(20);
    n_tests++;
    if (fe_rise !== 0 || pv_rise !== 0) begin
      n_fail++;
      $display("FAIL resync_drop: got fe=%0d pv=%0d, expected 0 0", fe_rise, pv_rise);
    end
    send_packet(8'h28, 8'h03, 8'hFD);
    n_tests++;
    if (pv_rise !== 1 || xpos !== 12'd403 || ypos !== 12'd303) begin
      n_fail++;
      $display("FAIL resync_pkt: got pv=%0d x=%0d y=%0d, expected pv=1 x=403 y=303", pv_rise, xpos, ypos);
    end
  endtask

  task automatic test_reset_midframe();
    apply_reset();
    send_byte(8'h08, 1'b0, -1);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    apply_reset();
    send_packet(8'h08, 8'h05, 8'h03);
    n_tests++;
    if (pv_rise !== 1 || fe_rise !== 0 || xpos !== 12'd405 || ypos !== 12'd297) begin
      n_fail++;
      $display("FAIL midreset_pkt: got pv=%0d fe=%0d x=%0d y=%0d, expected pv=1 fe=0 x=405 y=297", pv_rise, fe_rise, xpos, ypos);
    end
  endtask

  task automatic test_glitch();
    apply_reset();
    send_byte(8'h08, 1'b0, 4);
    send_byte(8'h05, 1'b0, 6);
    send_byte(8'h03, 1'b0, 9);
    wait_cycles(20);
    n_tests++;
    if (pv_rise !== 1 || fe_rise !== 0 || xpos !== 12'd405 || ypos !== 12'd297) begin
      n_fail++;
      $display("FAIL glitch_pkt: got pv=%0d fe=%0d x=%0d y=%0d, expected pv=1 fe=0 x=405 y=297", pv_rise, fe_rise, xpos, ypos);
    end
  endtask

  task automatic test_overflow();
    apply_reset();
    send_packet(8'h4A, 8'h50, 8'h10);
    model_packet(8'h4A, 8'h50, 8'h10);
    n_tests++;
    if ({xpos, ypos, left, right} !== {12'(mx), 12'(my), ml, mr} || xpos !== 12'd400) begin
      n_fail++;
      $display("FAIL ovf_x: got x=%0d y=%0d r=%0b, expected x=%0d y=%0d r=%0b", xpos, ypos, right, mx, my, mr);
    end
    send_packet(8'h89, 8'h20, 8'h40);
    model_packet(8'h89, 8'h20, 8'h40);
    n_tests++;
    if ({xpos, ypos, left, right} !== {12'(mx), 12'(my), ml, mr}) begin
      n_fail++;
      $display("FAIL ovf_y: got x=%0d y=%0d l=%0b r=%0b, expected x=%0d y=%0d l=%0b r=%0b", xpos, ypos, left, right, mx, my, ml, mr);
    end
  endtask

  task automatic test_random();
    logic [7:0] b0, b1, b2;
    apply_reset();
    for (int i = 0; i < 16; i++) begin
      b0 = 8'($urandom_range(0, 255));
      b0[3] = 1'b1;
      b0[6] = ($urandom_range(0, 7) == 0);
      b0[7] = ($urandom_range(0, 7) == 0);
      b1 = 8'($urandom_range(0, 255));
      b2 = 8'($urandom_range(0, 255));
      clear_mon();
      send_packet(b0, b1, b2);
      model_packet(b0, b1, b2);
      n_tests++;
      if (pv_rise !== 1 || fe_rise !== 0 || {xpos, ypos, left, right} !== {12'(mx), 12'(my), ml, mr}) begin
        n_fail++;
        $display("FAIL rand_%0d: pkt %h %h %h got pv=%0d fe=%0d x=%0d y=%0d l=%0b r=%0b, expected x=%0d y=%0d l=%0b r=%0b",
                 i, b0, b1, b2, pv_rise, fe_rise, xpos, ypos, left, right, mx, my, ml, mr);
      end
    end
  endtask

  task automatic test_exclusive();
    n_tests++;
    if (both_cnt !== 0) begin
      n_fail++;
      $display("FAIL strobe_overlap: got %0d cycles with pkt_valid and frame_err both high, expected 0", both_cnt);
    end
  endtask

  initial begin
    both_cnt = 0;
    test_reset();
    test_basic();
    test_saturate();
    test_parity();
    test_timeout();
    test_resync();
    test_reset_midframe();
    test_glitch();
    test_overflow();
    test_random();
    test_exclusive();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
